// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : timer_scheduler
//  Purpose  : Shares one 500 ms hardware timer among NREQ clients. A
//             round-robin arbiter picks a requester, loads its period count,
//             then runs the timer until that many timeout pulses have
//             arrived. Completion is signalled with a one-cycle done pulse.
//             If the owner drops its request, the grant is aborted.
//  Ports    : clk           - rising-edge clock
//             rst           - synchronous, active-low reset
//             req           - per-client request bits
//             periods       - per-client period counts, CW bits each
//             timer_timeout - one-cycle pulse from the shared timer
//             timer_en      - enable to the shared timer
//             timer_rst_n   - active-low synchronous clear to the shared timer
//             grant         - one-hot owner of the timer (zero when none)
//             done          - one-cycle completion pulse per client
//             busy          - high whenever the scheduler is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module timer_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] periods,
  input  logic              timer_timeout,
  output logic              timer_en,
  output logic              timer_rst_n,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   last;
  logic [CW-1:0]   remaining;

  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic [IW-1:0]   cand;

  // Round-robin search starting at last+1. The loop walks offsets from the
  // far end down to 1 so the closest requester is the final assignment and
  // therefore wins. Offset NREQ wraps back to last itself (lowest priority).
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + IW'(k);
      if (req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      winner      <= '0;
      last        <= IW'(NREQ - 1);
      remaining   <= '0;
      grant       <= '0;
      done        <= '0;
      busy        <= 1'b0;
      timer_en    <= 1'b0;
      timer_rst_n <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state       <= LOAD;
            winner      <= pick;
            remaining   <= periods[int'(pick)*CW +: CW];
            grant       <= ONE << pick;
            busy        <= 1'b1;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
          end
        end

        LOAD: begin
          if (!req[winner]) begin
            // Owner withdrew: release without completion.
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
            last        <= winner;
          end else if (remaining == '0) begin
            state       <= FIN;
            grant       <= '0;
            done        <= ONE << winner;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
          end else begin
            state       <= RUN;
            timer_en    <= 1'b1;
            timer_rst_n <= 1'b1;
          end
        end

        RUN: begin
          // Abort is tested first so it beats a coincident final timeout.
          if (!req[winner]) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            timer_en    <= 1'b0;
            timer_rst_n <= 1'b0;
            last        <= winner;
          end else if (timer_timeout) begin
            if (remaining <= CW'(1)) begin
              state       <= FIN;
              remaining   <= '0;
              grant       <= '0;
              done        <= ONE << winner;
              timer_en    <= 1'b0;
              timer_rst_n <= 1'b0;
            end else begin
              remaining <= remaining - CW'(1);
            end
          end
        end

        FIN: begin
          state <= IDLE;
          last  <= winner;
          busy  <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          grant       <= '0;
          busy        <= 1'b0;
          timer_en    <= 1'b0;
          timer_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of requesting clients; only the value 4 is supported.
REQ-002 SHALL have parameter CW, default 3, meaning the width of each client's period count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req, input, NREQ bits: req[i]=1 means client i requests the shared 500 ms timer.
REQ-006 SHALL have port periods, input, NREQ*CW bits: periods[i*CW +: CW] is the number of 500 ms periods requested by client i.
REQ-007 SHALL have port timer_timeout, input, 1 bit: the one-cycle timeout pulse from the shared 500 ms timer.
REQ-008 SHALL have port timer_en, output, 1 bit: the enable to the shared timer.
REQ-009 SHALL have port timer_rst_n, output, 1 bit: the active-low synchronous reset to the shared timer.
REQ-010 SHALL have port grant, output, NREQ bits: a one-hot vector naming the client that owns the timer, or all-zero when no client does.
REQ-011 SHALL have port done, output, NREQ bits: done[i] pulses for one cycle when client i's request completes.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-013 SHALL implement a four-state FSM with states IDLE, LOAD, RUN and FIN, and all outputs SHALL be registered.
REQ-014 In IDLE with any req bit high, the block SHALL pick a winner by round-robin, searching from (last+1) mod NREQ, and SHALL move to LOAD.
REQ-015 In IDLE with all req bits low, the block SHALL stay in IDLE.
REQ-016 On leaving IDLE, the block SHALL latch the winner index and that client's periods value into remaining (CW bits).
REQ-017 LOAD SHALL last one cycle, with grant already showing the winner and timer_rst_n=0, so the timer starts cleared.
REQ-018 From LOAD, the block SHALL go to FIN if remaining==0, and otherwise to RUN.
REQ-019 In RUN, timer_en=1, timer_rst_n=1 and grant SHALL be held.
REQ-020 In RUN, each cycle with timer_timeout=1 SHALL decrement remaining.
REQ-021 In RUN, a timer_timeout pulse seen while remaining==1 SHALL cause a transition to FIN.
REQ-022 In FIN, which lasts one cycle, done[winner]=1, grant=0, timer_en=0 and timer_rst_n=0.
REQ-023 In FIN, last SHALL be set to the winner, and the next state SHALL be IDLE.
REQ-024 Abort: if req[winner] drops in LOAD or RUN, the block SHALL go to IDLE next cycle with no done pulse, grant=0 and timer_en=0; last SHALL still update to the winner.
REQ-025 If abort and the final timeout occur in the same cycle, abort SHALL win and no done pulse SHALL be produced.
REQ-026 timer_timeout SHALL be ignored in IDLE, LOAD and FIN.
REQ-027 Requests from other clients SHALL never pre-empt the current owner; they wait in req.
REQ-028 periods SHALL be sampled only at winner selection; later changes SHALL have no effect on the active grant.
REQ-029 Latency: req seen in IDLE at edge N SHALL give grant at N+1, timer_en at N+2, and done one cycle after the edge sampling the final timeout.
REQ-030 There SHALL be at least one IDLE cycle between FIN and the next LOAD.
REQ-031 grant SHALL never have more than one bit set; done SHALL never have more than one bit set, and only in FIN.
REQ-032 remaining SHALL never wrap below zero.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL enter IDLE.
REQ-034 While rst=0, outputs SHALL be grant=0, done=0, busy=0, timer_en=0 and timer_rst_n=0.
REQ-035 While rst=0, remaining SHALL be 0 and last SHALL be NREQ-1, so client 0 has first priority after reset.
REQ-036 A reset asserted in any state, including mid-RUN, SHALL take effect at the next edge with no done pulse produced.

Verification
REQ-037 The bench SHALL cover: req=0001 with periods0=3, 3 timeout pulses 10 cycles apart -> grant=0001 one cycle after req, done=0001 once after the 3rd pulse, timer_en high only in RUN.
REQ-038 The bench SHALL cover: req=1111 held, all periods=1 -> grants in order 0001, 0010, 0100, 1000, 0001, with each FIN followed by at least one IDLE cycle.
REQ-039 The bench SHALL cover: client 2 with periods=0 -> LOAD then FIN, done=0100, and timer_en never asserted.
REQ-040 The bench SHALL cover: client 1 with periods=5, req[1] dropped after 2 timeouts -> grant=0 next cycle, no done, busy=0.
REQ-041 The bench SHALL cover: req[1] dropped in the same cycle as the 5th timeout -> no done pulse.
REQ-042 The bench SHALL cover: rst=0 mid-RUN -> all outputs return to reset values next edge; after release with req=1111, client 0 is granted first.
